// File: rtl/axis_ramp_generator.sv
// Triggered signed ramp source driving a DAC over AXI-Stream, saturating to 14-bit signed range.
// Define RAMP_DOWN_EN to add a mirrored falling leg after the rising ramp.
//
// state | meaning
// IDLE  | output the last transmitted sample, wait for a ramp_rq rising edge
// RISE  | emit cfg_len samples start, start+step, ... (saturated)
// FALL  | (RAMP_DOWN_EN) emit cfg_len-1 samples stepping back down
module axis_ramp_generator #(
  parameter int COUNTER_WIDTH = 18
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic signed [15:0]       cfg_start,
  input  logic signed [15:0]       cfg_step,
  input  logic [COUNTER_WIDTH-1:0] cfg_len,
  input  logic                     ramp_rq,
  output logic                     busy,
  output logic                     done,
  output logic signed [15:0]       m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

`ifdef RAMP_DOWN_EN
  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;
`else
  typedef enum logic [1:0] {IDLE, RISE} state_t;
`endif

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
  localparam logic signed [16:0]       SAT_MAX = 17'sd8191;
  localparam logic signed [16:0]       SAT_MIN = -17'sd8192;

  state_t                     state_q, state_d;
  logic                       rq_q;
  logic signed [15:0]         acc_q, acc_d;
  logic signed [15:0]         hold_q, hold_d;
  logic signed [15:0]         step_q, step_d;
  logic [COUNTER_WIDTH-1:0]   cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0]   len_q, len_d;
  logic                       done_q, done_d;
  logic                       trigger;
  logic                       handshake;
  logic signed [16:0]         sum_up;

  function automatic logic signed [15:0] sat(input logic signed [16:0] s);
    if (s > SAT_MAX) return SAT_MAX[15:0];
    if (s < SAT_MIN) return SAT_MIN[15:0];
    return s[15:0];
  endfunction

  assign trigger   = ramp_rq & ~rq_q;
  assign handshake = m_axis_tvalid & m_axis_tready;
  assign sum_up    = $signed({acc_q[15], acc_q}) + $signed({step_q[15], step_q});

`ifdef RAMP_DOWN_EN
  localparam logic [COUNTER_WIDTH-1:0] CNT_TWO = COUNTER_WIDTH'(2);
  logic signed [16:0] sum_dn;
  assign sum_dn = $signed({acc_q[15], acc_q}) - $signed({step_q[15], step_q});
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    hold_d  = hold_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A zero-length request is dropped entirely
        if (trigger && (cfg_len != '0)) begin
          state_d = RISE;
          acc_d   = cfg_start;
          step_d  = cfg_step;
          len_d   = cfg_len;
          cnt_d   = '0;
        end
      end
      RISE: begin
        if (handshake) begin
          hold_d = acc_q;
          acc_d  = sat(sum_up);
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == len_q - CNT_ONE) begin
`ifdef RAMP_DOWN_EN
            if (len_q == CNT_ONE) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FALL;
              acc_d   = sat(sum_dn);
              cnt_d   = '0;
            end
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef RAMP_DOWN_EN
      FALL: begin
        if (handshake) begin
          hold_d = acc_q;
          acc_d  = sat(sum_dn);
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == len_q - CNT_TWO) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      rq_q    <= 1'b0;
      acc_q   <= '0;
      hold_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rq_q    <= ramp_rq;
      acc_q   <= acc_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign m_axis_tvalid = 1'b1;
  assign m_axis_tdata  = (state_q == IDLE) ? hold_q : acc_q;

endmodule

// File: tb/tb_axis_ramp_generator.sv
// Self-checking bench for axis_ramp_generator; expected ramps come from a list-based model.
// Build with +define+RAMP_DOWN_EN to check the falling-leg variant.
module tb_axis_ramp_generator;
  localparam int CW = 18;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic signed [15:0]   cfg_start = '0;
  logic signed [15:0]   cfg_step = '0;
  logic [CW-1:0]        cfg_len = '0;
  logic                 ramp_rq = 1'b0;
  logic                 busy;
  logic                 done;
  logic signed [15:0]   m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int last_hold = 0;

  axis_ramp_generator #(.COUNTER_WIDTH(CW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_start     (cfg_start),
    .cfg_step      (cfg_step),
    .cfg_len       (cfg_len),
    .ramp_rq       (ramp_rq),
    .busy          (busy),
    .done          (done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  function automatic int clampv(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  // Whole expected sample list for one ramp
  task automatic build_model(input int s, input int st, input int l);
    int v;
    exp_q.delete();
    v = s;
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(v);
      v = clampv(v + st);
    end
`ifdef RAMP_DOWN_EN
    if (l > 1) begin
      v = exp_q[l-1];
      for (int i = 0; i < l - 1; i++) begin
        v = clampv(v - st);
        exp_q.push_back(v);
      end
    end
`endif
  endtask

  task automatic start_ramp(input int s, input int st, input int l);
    cfg_start = 16'(s);
    cfg_step  = 16'(st);
    cfg_len   = CW'(l);
    ramp_rq   = 1'b1;
    @(negedge aclk);
    ramp_rq = 1'b0;
    build_model(s, st, l);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy got %b want 1", busy);
    end
    checks++;
    if (m_axis_tdata !== 16'(s)) begin
      errors++;
      $display("FAIL start_data got %0d want %0d", m_axis_tdata, s);
    end
  endtask

  // mode 0: tready=1, 1: toggle 1,0,..., 2: random; disturb pulses ramp_rq and scrambles cfg mid-ramp
  task automatic follow_ramp(input string name, input int mode, input bit disturb);
    int got_q[$];
    bit prev_stall;
    bit tog;
    bit tr;
    logic signed [15:0] prev_data;
    int cyc;
    prev_stall = 1'b0;
    tog = 1'b1;
    prev_data = '0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 500) begin
      if (prev_stall) begin
        checks++;
        if (m_axis_tdata !== prev_data) begin
          errors++;
          $display("FAIL %s stall_hold got %0d want %0d", name, m_axis_tdata, prev_data);
        end
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s early_done got %b want 0", name, done);
      end
      if (disturb && cyc == 1) begin
        ramp_rq   = 1'b1;
        cfg_start = 16'($urandom);
        cfg_step  = 16'($urandom);
        cfg_len   = CW'($urandom_range(1, 20));
      end else if (disturb && cyc == 2) begin
        ramp_rq = 1'b0;
      end
      case (mode)
        0:       tr = 1'b1;
        1:       begin tr = tog; tog = ~tog; end
        default: tr = 1'($urandom_range(0, 1));
      endcase
      m_axis_tready = tr;
      if (tr) got_q.push_back(int'(m_axis_tdata));
      prev_stall = ~tr;
      prev_data  = m_axis_tdata;
      @(negedge aclk);
      cyc++;
    end
    ramp_rq = 1'b0;
    checks++;
    if (cyc >= 500) begin
      errors++;
      $display("FAIL %s timeout busy=%b after %0d cycles want 0", name, busy, cyc);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse got %b want 1", name, done);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s sample_count got %0d want %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] != exp_q[i]) begin
          errors++;
          $display("FAIL %s sample[%0d] got %0d want %0d", name, i, got_q[i], exp_q[i]);
        end
      end
    end
    if (exp_q.size() > 0) last_hold = exp_q[exp_q.size()-1];
    checks++;
    if (m_axis_tdata !== 16'(last_hold)) begin
      errors++;
      $display("FAIL %s idle_hold got %0d want %0d", name, m_axis_tdata, last_hold);
    end
    @(negedge aclk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done got done=%b busy=%b want 0 0", name, done, busy);
    end
    checks++;
    if (m_axis_tdata !== 16'(last_hold) || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_out got data=%0d valid=%b want %0d 1", name, m_axis_tdata, m_axis_tvalid, last_hold);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_axis_tdata !== 16'sd0 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_out got busy=%b done=%b data=%0d valid=%b want 0 0 0 1",
               busy, done, m_axis_tdata, m_axis_tvalid);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || m_axis_tdata !== 16'sd0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b data=%0d want 0 0", busy, m_axis_tdata);
    end
    last_hold = 0;
  endtask

  task automatic test_basic();
    m_axis_tready = 1'b1;
    start_ramp(0, 100, 4);
    follow_ramp("basic", 0, 1'b0);
  endtask

  task automatic test_backpressure();
    start_ramp(0, 100, 4);
    follow_ramp("toggle", 1, 1'b0);
  endtask

  task automatic test_saturation();
    m_axis_tready = 1'b1;
    start_ramp(8000, 100, 4);
    follow_ramp("sat_pos", 0, 1'b0);
    start_ramp(-8100, -100, 4);
    follow_ramp("sat_neg", 0, 1'b0);
  endtask

  task automatic test_len_zero();
    cfg_len = '0;
    cfg_start = 16'sd1234;
    ramp_rq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      ramp_rq = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || m_axis_tdata !== 16'(last_hold)) begin
        errors++;
        $display("FAIL len_zero got busy=%b done=%b data=%0d want 0 0 %0d",
                 busy, done, m_axis_tdata, last_hold);
      end
    end
  endtask

  task automatic test_retrigger();
    m_axis_tready = 1'b1;
    start_ramp(-300, 50, 6);
    follow_ramp("retrig", 0, 1'b1);
  endtask

  task automatic test_trigger_on_done();
    int cyc;
    m_axis_tready = 1'b1;
    start_ramp(10, 5, 2);
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_trig first_done got %b want 1", done);
    end
    start_ramp(7, 3, 3);
    follow_ramp("done_trig", 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    m_axis_tready = 1'b1;
    start_ramp(0, 100, 4);
    repeat (2) @(negedge aclk);
    aresetn   = 1'b0;
    ramp_rq   = 1'b1;
    cfg_start = -16'sd50;
    cfg_step  = 16'sd25;
    cfg_len   = CW'(3);
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_axis_tdata !== 16'sd0 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b data=%0d valid=%b want 0 0 0 1",
               busy, done, m_axis_tdata, m_axis_tvalid);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    ramp_rq = 1'b0;
    checks++;
    if (busy !== 1'b1 || m_axis_tdata !== -16'sd50 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b data=%0d done=%b want 1 -50 0",
               busy, m_axis_tdata, done);
    end
    build_model(-50, 25, 3);
    follow_ramp("after_reset", 0, 1'b0);
  endtask

  task automatic test_random();
    logic signed [15:0] rs, rt;
    for (int n = 0; n < 10; n++) begin
      rs = 16'($urandom);
      rt = 16'($urandom_range(0, 2000)) - 16'sd1000;
      if (n % 3 == 0) rt = 16'($urandom);
      start_ramp(int'(rs), int'(rt), int'($urandom_range(1, 12)));
      follow_ramp("random", 2, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_len_zero();
    test_retrigger();
    test_trigger_on_done();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_ramp_generator.md
AXIS_RAMP_GENERATOR -- requirements
Module: axis_ramp_generator

Interface
REQ-001 Parameter COUNTER_WIDTH, default 18, SHALL set the width of cfg_len and the internal sample counter.
REQ-002 aclk  input  1  clock; all logic SHALL be on its rising edge.
REQ-003 aresetn  input  1  reset, synchronous, active-low.
REQ-004 cfg_start  input  16  signed first sample of the ramp.
REQ-005 cfg_step  input  16  signed per-sample increment.
REQ-006 cfg_len  input  COUNTER_WIDTH  unsigned number of rising-ramp samples.
REQ-007 ramp_rq  input  1  ramp request level; the rising edge triggers a ramp.
REQ-008 busy  output  1  high while the state is RISE or FALL.
REQ-009 done  output  1  one-cycle pulse on return to IDLE after a ramp.
REQ-010 m_axis_tdata  output  16  signed DAC sample.
REQ-011 m_axis_tvalid  output  1  sample valid.
REQ-012 m_axis_tready  input  1  DAC accepts a sample.

Function
REQ-013 The block SHALL register ramp_rq once; a trigger SHALL be ramp_rq=1 with the registered value 0.
REQ-014 States SHALL be IDLE, RISE and FALL, all registered.
REQ-015 m_axis_tvalid SHALL be 1 in every state after reset; the handshake is tvalid&tready.
REQ-016 In IDLE, m_axis_tdata SHALL equal the hold register, which is the last transmitted ramp sample (0 after reset).
REQ-017 On a trigger in IDLE with cfg_len!=0, the block SHALL:
  - capture cfg_start, cfg_step and cfg_len;
  - load the accumulator with cfg_start and clear the counter;
  - enter RISE on that edge, so m_axis_tdata=cfg_start from the next cycle.
REQ-018 A trigger in IDLE with cfg_len=0 SHALL be ignored: no state change, no done.
REQ-019 In RISE/FALL, m_axis_tdata SHALL equal the accumulator; the accumulator and counter SHALL advance only on a handshake.
REQ-020 Without a handshake, tdata, the accumulator and the counter SHALL hold.
REQ-021 Each RISE handshake SHALL:
  - set accumulator <= sat(acc + step) and counter++;
  - copy the transmitted sample into the hold register.
REQ-022 sat() SHALL compute a 17-bit signed sum and clamp it to [-8192, 8191].
REQ-023 The RISE handshake with counter = len-1 SHALL end RISE; the next state is set by REQ-030/031.
REQ-024 Triggers while busy SHALL be ignored; there is no retrigger and no queueing.
REQ-025 Changes on the cfg_* inputs while busy SHALL NOT affect the running ramp.
REQ-026 done SHALL be asserted for exactly one cycle, the first cycle back in IDLE.
REQ-027 A trigger in the same cycle as done SHALL be accepted (already in IDLE).

Reset
REQ-028 With aresetn=0 at a clock edge, the block SHALL:
  - go to IDLE with accumulator, counter and hold register at 0;
  - set busy=0, done=0, m_axis_tdata=0, m_axis_tvalid=1;
  - clear the registered ramp_rq.
REQ-029 Reset mid-ramp SHALL abort the ramp with no done pulse; a ramp_rq held high through release SHALL trigger on the first cycle after release.

Configuration
REQ-030 With macro RAMP_DOWN_EN defined, the end of RISE SHALL:
  - enter FALL with accumulator <= sat(last rise sample - step) and counter cleared;
  - in FALL, set accumulator <= sat(acc - step) on each handshake;
  - emit cfg_len-1 samples, then return to IDLE;
  - skip FALL and go straight to IDLE when cfg_len=1.
REQ-031 Without RAMP_DOWN_EN, the end of RISE SHALL enter IDLE directly, and the FALL state and its logic SHALL NOT be synthesized.

Verification
REQ-032 The bench SHALL cover:
  - start=0, step=100, len=4, tready=1 -> tdata 0,100,200,300; then IDLE holding 300, busy low, one done pulse.
  - Same config, tready toggling 1,0,1,0 -> each value held until accepted; exactly 4 accepted samples.
  - start=8000, step=100, len=4 -> 8000,8100,8191,8191; negative case start=-8100, step=-100 -> clamps at -8192.
  - len=0 trigger -> no busy, no done; trigger during RISE -> ramp unchanged, single done.
  - aresetn low after the 2nd sample -> tdata=0, IDLE, no done; ramp_rq held high -> new ramp right after release.
  - RAMP_DOWN_EN, start=0, step=100, len=4 -> 0,100,200,300,200,100,0; then hold 0 and one done pulse.
